image_assembler: RTL and testbench
==================================

IMAGE_ASSEMBLER -- requirements
Module: image_assembler

Interface
REQ-001 Parameter NUM_BYTES, default 784, number of pixel bytes per image.
REQ-002 Parameter IMG_SZ, default NUM_BYTES<<3, image vector width in bits.
REQ-003 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 Parameter TIMEOUT, default 50000, maximum idle cycles between bytes inside a frame.
REQ-005 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_data  input  8  incoming byte from the serial receiver.
REQ-009 in_valid  input  1  in_data valid this cycle.
REQ-010 in_ready  output  1  block can accept a byte; transfer occurs when in_valid && in_ready at a clock edge.
REQ-011 image  output  IMG_SZ  assembled image; byte k occupies bits [8k+7:8k].
REQ-012 image_valid  output  1  complete image held on image.
REQ-013 image_ack  input  1  consumer has taken the image.
REQ-014 frame_err  output  1  one-cycle pulse on frame timeout.
REQ-015 busy  output  1  high while in LOAD.

Function
REQ-016 FSM states SYNC, LOAD, DONE shall be used.
REQ-017 In SYNC: in_ready=1, and bytes are dropped.
REQ-018 In SYNC, an accepted byte equal to SYNC_BYTE shall move the FSM to LOAD and clear the byte count.
REQ-019 In LOAD: in_ready=1, busy=1, and each accepted byte is written to image[8*cnt+7:8*cnt] with cnt incremented.
REQ-020 In LOAD, SYNC_BYTE values shall be treated as ordinary data.
REQ-021 Acceptance of byte cnt==NUM_BYTES-1 shall move the FSM to DONE; image_valid shall be high the following cycle (1-cycle latency).
REQ-022 In DONE: in_ready=0, image_valid=1, and image stable; in_valid is ignored.
REQ-023 image_ack shall be sampled only in DONE; image_ack=1 moves the FSM to SYNC and deasserts image_valid next cycle.
REQ-024 image_ack outside DONE shall have no effect.
REQ-025 In LOAD, a gap counter shall clear on every accepted byte and increment otherwise.
REQ-026 When the gap counter reaches TIMEOUT-1, frame_err shall pulse for one cycle and the FSM shall return to SYNC with cnt=0; image_valid stays 0.
REQ-027 If a byte is accepted in the same cycle the gap counter reaches TIMEOUT-1, the byte wins: no timeout.
REQ-028 cnt width shall be $clog2(NUM_BYTES); the gap counter width shall be $clog2(TIMEOUT).
REQ-029 Neither counter shall wrap in normal operation.
REQ-030 Bits of image not yet rewritten in a new frame shall retain their old values; consumers use image only while image_valid=1.

Reset
REQ-031 rst_n low shall force state=SYNC, cnt=0, gap=0, image_valid=0, frame_err=0, busy=0, in_ready=1 (combinational from state), and image=0.
REQ-032 Reset mid-LOAD or mid-DONE shall discard the frame; no frame_err pulse shall be produced.

Structure
REQ-033 Package image_pkg shall hold NUM_BYTES, IMG_SZ, SYNC_BYTE, the state enum type, and the byte typedef (logic [7:0]).
REQ-034 Package image_pkg shall be shared with the downstream LED shifter.
REQ-035 The gap counter shall be a sub-module gap_timer with inputs clk, rst_n, en, clr and output expired.
REQ-036 Byte count and image register shall remain in image_assembler.

Verification
REQ-037 Normal frame: A5 then bytes 00..FF repeating for 784 bytes -> image_valid 1 cycle after last byte; image[7:0]=00, image[15:8]=01, image[8*783+7:8*783]=0F.
REQ-038 Junk before sync: 3C,11,A5 then 784 bytes of 55 -> junk ignored; image all 55; busy high only after A5 is accepted.
REQ-039 Backpressure: in DONE, drive in_valid=1 with data 77 for 10 cycles -> in_ready=0 and image unchanged; image_ack=1 -> SYNC next cycle, in_ready=1.
REQ-040 Timeout (TIMEOUT=16): A5, 10 bytes, then idle -> frame_err single pulse 15 cycles after the last byte; state SYNC; image_valid never set.
REQ-041 Timeout boundary: byte arrives exactly on the expiry cycle -> no frame_err; frame completes normally.
REQ-042 Async reset: assert rst_n=0 after byte 400 between clock edges -> outputs reset immediately; a new A5 frame after release assembles correctly.

Source files
------------

// File: rtl/image_pkg.sv
// Shared image-frame definitions for the image assembler and the downstream LED shifter.
package image_pkg;

   localparam int unsigned NUM_BYTES = 784;
   localparam int unsigned IMG_SZ    = NUM_BYTES << 3;

   typedef logic [7:0] byte_t;

   localparam byte_t SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      StSync = 2'd0,
      StLoad = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/gap_timer.sv
// Idle-gap counter for frame reception; flags expiry once TIMEOUT-1 idle cycles have elapsed.
module gap_timer #(
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expired
);

   localparam int unsigned GapW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT - 1);

   logic [GapW-1:0] gap_q;

   assign expired = en && (gap_q == GapLast);

   // Holds at the expiry value instead of wrapping; the FSM leaves LOAD on that cycle anyway.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_q <= '0;
      end else if (clr || !en) begin
         gap_q <= '0;
      end else if (gap_q != GapLast) begin
         gap_q <= gap_q + 1'b1;
      end
   end

endmodule

// File: rtl/image_assembler.sv
// Assembles a framed byte stream (sync byte + NUM_BYTES payload) into one wide image vector.
module image_assembler import image_pkg::*; #(
   parameter int unsigned NUM_BYTES = image_pkg::NUM_BYTES,
   parameter int unsigned IMG_SZ    = NUM_BYTES << 3,
   parameter byte_t       SYNC_BYTE = image_pkg::SYNC_BYTE,
   parameter int unsigned TIMEOUT   = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [IMG_SZ-1:0] image,
   output logic              image_valid,
   input  logic              image_ack,
   output logic              frame_err,
   output logic              busy
);

   localparam int unsigned CntW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NUM_BYTES - 1);

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [IMG_SZ-1:0] image_q;
   logic              accept;
   logic              expired;

   assign in_ready    = (state_q != StDone);
   assign accept      = in_valid && in_ready;
   assign busy        = (state_q == StLoad);
   assign image_valid = (state_q == StDone);
   // An accepted byte on the expiry cycle cancels the timeout.
   assign frame_err   = busy && expired && !accept;
   assign image       = image_q;

   gap_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_gap_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (busy),
      .clr     (accept),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StSync;
         cnt_q   <= '0;
         image_q <= '0;
      end else begin
         unique case (state_q)
            StSync: begin
               if (accept && (in_data == SYNC_BYTE)) begin
                  state_q <= StLoad;
                  cnt_q   <= '0;
               end
            end
            StLoad: begin
               if (accept) begin
                  image_q[{cnt_q, 3'b000} +: 8] <= in_data;
                  if (cnt_q == LastCnt) begin
                     state_q <= StDone;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else if (expired) begin
                  state_q <= StSync;
                  cnt_q   <= '0;
               end
            end
            StDone: begin
               if (image_ack) begin
                  state_q <= StSync;
               end
            end
            default: begin
               state_q <= StSync;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_image_assembler.sv
// Scoreboard bench for image_assembler: frames, junk, backpressure, timeout and async reset.
module tb_image_assembler;
   import image_pkg::*;

   localparam int unsigned NBytes  = image_pkg::NUM_BYTES;
   localparam int unsigned ImgSz   = image_pkg::IMG_SZ;
   localparam int unsigned Timeout = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       in_data = 8'h00;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [ImgSz-1:0] image;
   logic             image_valid;
   logic             image_ack = 1'b0;
   logic             frame_err;
   logic             busy;

   image_assembler #(
      .NUM_BYTES (NBytes),
      .IMG_SZ    (ImgSz),
      .SYNC_BYTE (8'hA5),
      .TIMEOUT   (Timeout)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .image       (image),
      .image_valid (image_valid),
      .image_ack   (image_ack),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int ferr_cnt = 0;
   int ferr_cyc = -1;

   logic [ImgSz-1:0] exp_img = '0;
   logic [ImgSz-1:0] last_exp = '0;
   logic [ImgSz-1:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err) begin
         ferr_cnt++;
         ferr_cyc = cyc;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic byte_t pat(input int mode, input int k);
      case (mode)
         0:       return byte_t'(k);
         1:       return 8'h55;
         2:       return byte_t'(k * 7 + 3);
         default: return byte_t'(8'hC0 + k);
      endcase
   endfunction

   task automatic send_byte(input byte_t b);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic load_bytes(input int mode, input int first, input int last);
      for (int k = first; k <= last; k++) begin
         exp_img[8*k +: 8] = pat(mode, k);
         send_byte(pat(mode, k));
      end
   endtask

   function automatic int bad_bytes(input logic [ImgSz-1:0] ref_img);
      int bad = 0;
      for (int k = 0; k < int'(NBytes); k++)
         if (image[8*k +: 8] !== ref_img[8*k +: 8]) bad++;
      return bad;
   endfunction

   task automatic check_frame(input string tag);
      int waited = 0;
      logic [ImgSz-1:0] exp;
      while (!image_valid && waited < 8) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check_eq({tag, "_valid"}, 32'(image_valid), 32'd1);
      check_eq({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         last_exp = exp;
         check_eq({tag, "_bad_bytes"}, 32'(bad_bytes(exp)), 32'd0);
         check_eq({tag, "_b0"}, 32'(image[7:0]), 32'(exp[7:0]));
         check_eq({tag, "_blast"}, 32'(image[8*(NBytes-1) +: 8]), 32'(exp[8*(NBytes-1) +: 8]));
      end
   endtask

   task automatic ack_frame(input string tag);
      image_ack = 1'b1;
      @(posedge clk);
      #1;
      image_ack = 1'b0;
      check_eq({tag, "_ack_valid"}, 32'(image_valid), 32'd0);
      check_eq({tag, "_ack_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int c0;
      int f0;

      // Reset state
      #1;
      check_eq("rst_ready", 32'(in_ready), 32'd1);
      check_eq("rst_valid", 32'(image_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ferr", 32'(frame_err), 32'd0);
      check_eq("rst_img", 32'(|image), 32'd0);
      #21 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Normal frame: A5 then 00..FF repeating
      send_byte(8'hA5);
      check_eq("n_busy", 32'(busy), 32'd1);
      load_bytes(0, 0, NBytes - 1);
      check_eq("n_lat_valid", 32'(image_valid), 32'd1);
      check_eq("n_lat_busy", 32'(busy), 32'd0);
      exp_q.push_back(exp_img);
      check_frame("n");
      check_eq("n_b1", 32'(image[15:8]), 32'h01);
      check_eq("n_b783", 32'(image[8*783 +: 8]), 32'h0F);

      // Backpressure in DONE
      for (int i = 0; i < 10; i++) begin
         in_data  = 8'h77;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         check_eq("bp_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      check_eq("bp_valid", 32'(image_valid), 32'd1);
      check_eq("bp_img", 32'(bad_bytes(last_exp)), 32'd0);
      ack_frame("bp");

      // Ack outside DONE, then junk before sync
      image_ack = 1'b1;
      @(posedge clk);
      #1;
      image_ack = 1'b0;
      check_eq("ack_sync_ready", 32'(in_ready), 32'd1);
      check_eq("ack_sync_valid", 32'(image_valid), 32'd0);
      send_byte(8'h3C);
      check_eq("j_busy0", 32'(busy), 32'd0);
      send_byte(8'h11);
      check_eq("j_busy1", 32'(busy), 32'd0);
      send_byte(8'hA5);
      check_eq("j_busy2", 32'(busy), 32'd1);
      load_bytes(1, 0, 99);
      image_ack = 1'b1;
      load_bytes(1, 100, 100);
      image_ack = 1'b0;
      check_eq("j_ack_load_busy", 32'(busy), 32'd1);
      load_bytes(1, 101, NBytes - 1);
      exp_q.push_back(exp_img);
      check_frame("j");
      ack_frame("j");

      // Timeout: A5, 10 bytes, idle
      send_byte(8'hA5);
      load_bytes(3, 0, 9);
      c0 = cyc;
      f0 = ferr_cnt;
      repeat (20) @(posedge clk);
      #1;
      check_eq("to_pulses", 32'(ferr_cnt - f0), 32'd1);
      check_eq("to_delay", 32'(ferr_cyc - c0), 32'd15);
      check_eq("to_busy", 32'(busy), 32'd0);
      check_eq("to_ready", 32'(in_ready), 32'd1);
      check_eq("to_valid", 32'(image_valid), 32'd0);

      // Timeout boundary: byte accepted on the expiry cycle
      send_byte(8'hA5);
      load_bytes(0, 0, 9);
      f0 = ferr_cnt;
      repeat (15) @(posedge clk);
      #1;
      load_bytes(0, 10, NBytes - 1);
      check_eq("tb_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      exp_q.push_back(exp_img);
      check_frame("tb");
      ack_frame("tb");

      // Async reset mid-LOAD after byte 400
      send_byte(8'hA5);
      load_bytes(2, 0, 399);
      f0 = ferr_cnt;
      #2 rst_n = 1'b0;
      #1;
      exp_img = '0;
      check_eq("ar_busy", 32'(busy), 32'd0);
      check_eq("ar_ready", 32'(in_ready), 32'd1);
      check_eq("ar_valid", 32'(image_valid), 32'd0);
      check_eq("ar_img", 32'(|image), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("ar_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      send_byte(8'hA5);
      load_bytes(2, 0, NBytes - 1);
      exp_q.push_back(exp_img);
      check_frame("ar");
      ack_frame("ar");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
